// File: rtl/raster_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : raster_sequencer
//  Description : Sequences one triangle draw from the register file. It walks
//                the screen-clipped bounding box row-major, one pixel per
//                handshake, and updates the CSR through single-bit writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module raster_sequencer #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int COORD_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [63:0]        vertex_a_in,
    input  logic [63:0]        vertex_b_in,
    input  logic [63:0]        vertex_c_in,
    input  logic [63:0]        control_status_in,
    output logic [5:0]         csr_bit_address,
    output logic               csr_bit_load,
    output logic               csr_bit_data,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               pixel_valid,
    input  logic               pixel_ready,
    output logic               pixel_last,
    output logic               busy
);

    localparam logic [3:0] c_st_idle      = 4'd0;
    localparam logic [3:0] c_st_set_busy  = 4'd1;
    localparam logic [3:0] c_st_clr_done  = 4'd2;
    localparam logic [3:0] c_st_latch     = 4'd3;
    localparam logic [3:0] c_st_bbox      = 4'd4;
    localparam logic [3:0] c_st_scan      = 4'd5;
    localparam logic [3:0] c_st_clr_start = 4'd6;
    localparam logic [3:0] c_st_clr_abort = 4'd7;
    localparam logic [3:0] c_st_clr_busy  = 4'd8;
    localparam logic [3:0] c_st_set_done  = 4'd9;

    localparam logic [COORD_W-1:0] c_x_lim = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] c_y_lim = COORD_W'(SCREEN_H - 1);

    logic [3:0]         r_state;
    logic [3:0]         w_next;
    logic [COORD_W-1:0] r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
    logic [COORD_W-1:0] r_xmin, r_xmax, r_ymax, r_x, r_y;
    logic [COORD_W-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
    logic [COORD_W-1:0] w_xmax_clip, w_ymax_clip;
    logic               w_empty;
    logic               w_last;
    logic               w_unused;

    assign w_unused = ^{vertex_a_in[63:2*COORD_W], vertex_b_in[63:2*COORD_W],
                        vertex_c_in[63:2*COORD_W], control_status_in[63:4],
                        control_status_in[2]};

    // Unclipped extents of the latched vertices
    always_comb begin
        w_xmin = r_ax;
        w_xmax = r_ax;
        w_ymin = r_ay;
        w_ymax = r_ay;
        if (r_bx < w_xmin) w_xmin = r_bx;
        if (r_cx < w_xmin) w_xmin = r_cx;
        if (r_bx > w_xmax) w_xmax = r_bx;
        if (r_cx > w_xmax) w_xmax = r_cx;
        if (r_by < w_ymin) w_ymin = r_by;
        if (r_cy < w_ymin) w_ymin = r_cy;
        if (r_by > w_ymax) w_ymax = r_by;
        if (r_cy > w_ymax) w_ymax = r_cy;
    end

    assign w_xmax_clip = (w_xmax > c_x_lim) ? c_x_lim : w_xmax;
    assign w_ymax_clip = (w_ymax > c_y_lim) ? c_y_lim : w_ymax;
    assign w_empty     = (w_xmin > c_x_lim) || (w_ymin > c_y_lim);
    assign w_last      = (r_x == r_xmax) && (r_y == r_ymax);

    assign pixel_valid = (r_state == c_st_scan);
    assign pixel_last  = pixel_valid && w_last;
    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign busy        = (r_state != c_st_idle);

    always_comb begin
        w_next          = r_state;
        csr_bit_load    = 1'b0;
        csr_bit_address = 6'd0;
        csr_bit_data    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (control_status_in[0] && !control_status_in[1]) w_next = c_st_set_busy;
            end
            c_st_set_busy: begin
                csr_bit_load    = 1'b1;
                csr_bit_address = 6'd1;
                csr_bit_data    = 1'b1;
                w_next          = c_st_clr_done;
            end
            c_st_clr_done: begin
                csr_bit_load    = 1'b1;
                csr_bit_address = 6'd2;
                w_next          = c_st_latch;
            end
            c_st_latch: w_next = c_st_bbox;
            c_st_bbox:  w_next = w_empty ? c_st_clr_start : c_st_scan;
            c_st_scan: begin
                // A pixel accepted alongside ABORT still counts as delivered
                if (control_status_in[3] || (pixel_ready && w_last)) w_next = c_st_clr_start;
            end
            c_st_clr_start: begin
                csr_bit_load    = 1'b1;
                csr_bit_address = 6'd0;
                w_next          = c_st_clr_abort;
            end
            c_st_clr_abort: begin
                csr_bit_load    = 1'b1;
                csr_bit_address = 6'd3;
                w_next          = c_st_clr_busy;
            end
            c_st_clr_busy: begin
                csr_bit_load    = 1'b1;
                csr_bit_address = 6'd1;
                w_next          = c_st_set_done;
            end
            c_st_set_done: begin
                csr_bit_load    = 1'b1;
                csr_bit_address = 6'd2;
                csr_bit_data    = 1'b1;
                w_next          = c_st_idle;
            end
            default: w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_ax    <= '0;
            r_ay    <= '0;
            r_bx    <= '0;
            r_by    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_xmin  <= '0;
            r_xmax  <= '0;
            r_ymax  <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_st_latch: begin
                    r_ax <= vertex_a_in[COORD_W-1:0];
                    r_ay <= vertex_a_in[2*COORD_W-1:COORD_W];
                    r_bx <= vertex_b_in[COORD_W-1:0];
                    r_by <= vertex_b_in[2*COORD_W-1:COORD_W];
                    r_cx <= vertex_c_in[COORD_W-1:0];
                    r_cy <= vertex_c_in[2*COORD_W-1:COORD_W];
                end
                c_st_bbox: begin
                    r_xmin <= w_xmin;
                    r_xmax <= w_xmax_clip;
                    r_ymax <= w_ymax_clip;
                    r_x    <= w_xmin;
                    r_y    <= w_ymin;
                end
                c_st_scan: begin
                    if (pixel_ready && !w_last) begin
                        if (r_x == r_xmax) begin
                            r_x <= r_xmin;
                            r_y <= r_y + COORD_W'(1);
                        end else begin
                            r_x <= r_x + COORD_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_raster_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_raster_sequencer
//  Description : Self-checking bench: table-driven draws, hand-written reset
//                sequence and randomized draws against a bounding-box model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_raster_sequencer;

    localparam int SW = 640;
    localparam int SH = 480;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [63:0]   vertex_a_in, vertex_b_in, vertex_c_in;
    logic [63:0]   control_status_in;
    logic [5:0]    csr_bit_address;
    logic          csr_bit_load, csr_bit_data;
    logic [CW-1:0] pixel_x, pixel_y;
    logic          pixel_valid, pixel_ready, pixel_last, busy;

    raster_sequencer #(.SCREEN_W(SW), .SCREEN_H(SH), .COORD_W(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .vertex_a_in       (vertex_a_in),
        .vertex_b_in       (vertex_b_in),
        .vertex_c_in       (vertex_c_in),
        .control_status_in (control_status_in),
        .csr_bit_address   (csr_bit_address),
        .csr_bit_load      (csr_bit_load),
        .csr_bit_data      (csr_bit_data),
        .pixel_x           (pixel_x),
        .pixel_y           (pixel_y),
        .pixel_valid       (pixel_valid),
        .pixel_ready       (pixel_ready),
        .pixel_last        (pixel_last),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Register file model: host full writes, host ABORT set, DUT bit writes
    logic [63:0] r_csr;
    logic        host_we;
    logic [63:0] host_wdata;
    logic        host_abort;
    logic [6:0]  bit_log[$];

    always @(posedge clk) begin
        if (csr_bit_load) bit_log.push_back({csr_bit_address, csr_bit_data});
        if (reset) begin
            r_csr <= '0;
        end else begin
            if (host_we) r_csr <= host_wdata;
            if (host_abort) r_csr[3] <= 1'b1;
            if (csr_bit_load) r_csr[csr_bit_address] <= csr_bit_data;
        end
    end
    assign control_status_in = r_csr;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          last;
    } pix_t;

    typedef struct {
        int ax, ay, bx, by, cx, cy;
        int rmode;
        int abort_after;
        int exp_n;
        int exp_lx, exp_ly;
    } vec_t;

    pix_t exp_q[$];
    pix_t got_q[$];
    int   n_checks = 0;
    int   n_err = 0;

    task automatic check(input string name, input longint got, input longint expv);
        n_checks++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: every pixel of the clipped bounding box in row-major order
    task automatic build_model(input int ax, ay, bx, by, cx, cy);
        int x0, x1, y0, y1;
        pix_t p;
        exp_q.delete();
        x0 = (ax < bx) ? ((ax < cx) ? ax : cx) : ((bx < cx) ? bx : cx);
        x1 = (ax > bx) ? ((ax > cx) ? ax : cx) : ((bx > cx) ? bx : cx);
        y0 = (ay < by) ? ((ay < cy) ? ay : cy) : ((by < cy) ? by : cy);
        y1 = (ay > by) ? ((ay > cy) ? ay : cy) : ((by > cy) ? by : cy);
        if (x1 > SW - 1) x1 = SW - 1;
        if (y1 > SH - 1) y1 = SH - 1;
        if (x0 <= SW - 1 && y0 <= SH - 1) begin
            for (int y = y0; y <= y1; y++) begin
                for (int x = x0; x <= x1; x++) begin
                    p.x = CW'(x);
                    p.y = CW'(y);
                    p.last = (x == x1) && (y == y1);
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    task automatic start_draw(input int ax, ay, bx, by, cx, cy);
        vertex_a_in = {$urandom, 16'(ay), 16'(ax)};
        vertex_b_in = {$urandom, 16'(by), 16'(bx)};
        vertex_c_in = {$urandom, 16'(cy), 16'(cx)};
        host_wdata  = {$urandom, 28'($urandom), 1'b0, r_csr[2], 2'b01};
        host_we     = 1'b1;
        tick();
        host_we     = 1'b0;
    endtask

    // rmode: 0 ready high, 1 pattern 1,0,0,1, 2 random
    task automatic run_draw(input string tag, input int ax, ay, bx, by, cx, cy,
                            input int rmode, input int abort_after);
        int   lat, acc, hold_err, ab_err, seq_err, log_err, exp_n;
        bit   finished, prev_pend, ab_prev;
        pix_t cur, prev;
        logic [6:0] exp_log[6];
        exp_log = '{7'd3, 7'd4, 7'd0, 7'd6, 7'd2, 7'd5};
        build_model(ax, ay, bx, by, cx, cy);
        got_q.delete();
        bit_log.delete();
        pixel_ready = 1'b0;
        start_draw(ax, ay, bx, by, cx, cy);
        lat = -1; acc = 0; hold_err = 0; ab_err = 0;
        finished = 1'b0; prev_pend = 1'b0; ab_prev = 1'b0; prev = '0;
        for (int c = 0; c < 5000; c++) begin
            if (c > 1 && !busy) begin
                finished = 1'b1;
                break;
            end
            host_abort = 1'b0;
            cur = '{x: pixel_x, y: pixel_y, last: pixel_last};
            if (pixel_valid && lat < 0) begin
                lat = c;
                vertex_a_in = {$urandom, $urandom};
                vertex_b_in = {$urandom, $urandom};
                vertex_c_in = {$urandom, $urandom};
            end
            if (ab_prev && pixel_valid) ab_err++;
            if (prev_pend && !ab_prev && !(pixel_valid && cur == prev)) hold_err++;
            case (rmode)
                0:       pixel_ready = 1'b1;
                1:       pixel_ready = (c % 4 == 0) || (c % 4 == 3);
                default: pixel_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (pixel_valid && pixel_ready) begin
                got_q.push_back(cur);
                acc++;
                if (abort_after > 1 && acc == abort_after - 1) host_abort = 1'b1;
            end
            prev_pend = pixel_valid && !pixel_ready;
            ab_prev   = pixel_valid && control_status_in[3];
            prev      = cur;
            tick();
        end
        host_abort  = 1'b0;
        pixel_ready = 1'b0;
        check({tag, "_finished"}, finished, 1);
        exp_n = (abort_after > 0) ? abort_after : exp_q.size();
        if (exp_q.size() > 0) check({tag, "_latency"}, lat, 5);
        check({tag, "_count"}, got_q.size(), exp_n);
        seq_err = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] != exp_q[i]) seq_err++;
        check({tag, "_pixels"}, seq_err, 0);
        check({tag, "_hold"}, hold_err, 0);
        if (abort_after > 0) check({tag, "_abort_drop"}, ab_err, 0);
        check({tag, "_csr"}, r_csr[3:0], 4'b0100);
        log_err = (bit_log.size() != 6) ? 1 : 0;
        for (int i = 0; i < bit_log.size() && i < 6; i++)
            if (bit_log[i] != exp_log[i]) log_err++;
        check({tag, "_csr_writes"}, log_err, 0);
    endtask

    vec_t tbl[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        int sz;
        int bx0, by0, vx[3], vy[3];
        pixel_ready = 1'b0; host_we = 1'b0; host_abort = 1'b0; host_wdata = '0;
        vertex_a_in = '0; vertex_b_in = '0; vertex_c_in = '0;

        reset = 1'b1;
        repeat (3) tick();
        check("reset_valid", pixel_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_load", csr_bit_load, 0);
        check("reset_addr", csr_bit_address, 0);
        check("reset_xy", {pixel_x, pixel_y, pixel_last}, 0);
        reset = 1'b0;
        tick();

        tbl[0] = '{2, 3, 4, 1, 3, 5, 0, 0, 15, 4, 5};
        tbl[1] = '{2, 3, 4, 1, 3, 5, 1, 0, 15, 4, 5};
        tbl[2] = '{638, 478, 700, 479, 639, 600, 0, 0, 4, 639, 479};
        tbl[3] = '{700, 10, 700, 10, 700, 10, 0, 0, 0, 0, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[5] = '{0, 0, 9, 0, 0, 9, 0, 7, 7, 6, 0};
        for (int t = 0; t < 6; t++) begin
            string tag;
            tag = $sformatf("vec%0d", t);
            run_draw(tag, tbl[t].ax, tbl[t].ay, tbl[t].bx, tbl[t].by, tbl[t].cx,
                     tbl[t].cy, tbl[t].rmode, tbl[t].abort_after);
            check({tag, "_table_n"}, got_q.size(), tbl[t].exp_n);
            if (got_q.size() > 0)
                check({tag, "_table_lastxy"}, {got_q[$].x, got_q[$].y},
                      {16'(tbl[t].exp_lx), 16'(tbl[t].exp_ly)});
        end

        // Reset in the middle of a scan
        pixel_ready = 1'b1;
        bit_log.delete();
        start_draw(0, 0, 9, 0, 0, 9);
        repeat (8) tick();
        check("mid_reset_scanning", pixel_valid, 1);
        sz = bit_log.size();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_valid", pixel_valid, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_load", csr_bit_load, 0);
        tick();
        tick();
        check("mid_reset_idle", busy, 0);
        check("mid_reset_no_writes", bit_log.size(), sz);
        pixel_ready = 1'b0;

        for (int r = 0; r < 16; r++) begin
            bx0 = $urandom_range(0, 1) ? SW - 6 : 0;
            by0 = $urandom_range(0, 1) ? SH - 6 : 0;
            for (int k = 0; k < 3; k++) begin
                vx[k] = bx0 + $urandom_range(0, 9);
                vy[k] = by0 + $urandom_range(0, 9);
            end
            run_draw($sformatf("rnd%0d", r), vx[0], vy[0], vx[1], vy[1], vx[2], vy[2], 2, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/raster_sequencer.md
Name: raster_sequencer

Overview:
- Sequences one triangle draw from the register file contents: vertex A/B/C words and the 64-bit control/status register (CSR).
- Detects START in the CSR, raises BUSY, latches vertices, computes a screen-clipped bounding box and scans it row-major, emitting one pixel coordinate per handshake to the downstream edge/shading unit.
- On completion or abort, updates the CSR through the register file's single-bit write port: clears START and BUSY, sets DONE.

Parameters:
- SCREEN_W, 640, screen width in pixels; x clipped to SCREEN_W-1
- SCREEN_H, 480, screen height in pixels; y clipped to SCREEN_H-1
- COORD_W, 16, coordinate width of x/y fields and pixel outputs

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vertex_a_in  in  64  vertex A; x=[15:0], y=[31:16] unsigned, [63:32] ignored
- vertex_b_in  in  64  vertex B, same format
- vertex_c_in  in  64  vertex C, same format
- control_status_in  in  64  CSR; bit0 START, bit1 BUSY, bit2 DONE, bit3 ABORT
- csr_bit_address  out  6  CSR bit index for single-bit write
- csr_bit_load  out  1  one-cycle single-bit write strobe, active high
- csr_bit_data  out  1  value written to the addressed bit
- pixel_x  out  COORD_W  current pixel x
- pixel_y  out  COORD_W  current pixel y
- pixel_valid  out  1  pixel_x/pixel_y are valid
- pixel_ready  in  1  downstream accepts the pixel
- pixel_last  out  1  qualifies the final pixel of the bounding box
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0; internal bbox and scan registers 0. Reset mid-draw aborts with no CSR writes. The register file resets its CSR independently.
- State sequence: IDLE -> SET_BUSY -> CLR_DONE -> LATCH -> BBOX -> SCAN -> CLR_START -> CLR_ABORT -> CLR_BUSY -> SET_DONE -> IDLE.
- IDLE: leave when control_status_in[0]=1 and control_status_in[1]=0.
- Bit-write states last exactly one cycle each, with csr_bit_load=1 for that cycle only:
  - SET_BUSY: address 1, data 1
  - CLR_DONE: address 2, data 0
  - CLR_START: address 0, data 0
  - CLR_ABORT: address 3, data 0
  - CLR_BUSY: address 1, data 0
  - SET_DONE: address 2, data 1
- In all other states csr_bit_load=0, and csr_bit_address/csr_bit_data are 0.
- LATCH: register the three x/y pairs. Vertex inputs are not used after this cycle.
- BBOX: xmin/xmax/ymin/ymax are the unsigned min/max of the three vertices.
  - Clip xmax to SCREEN_W-1 and ymax to SCREEN_H-1.
  - If xmin>SCREEN_W-1 or ymin>SCREEN_H-1 the box is empty: go directly to CLR_START with no pixels emitted.
  - Otherwise set (x,y)=(xmin,ymin) and enter SCAN.
- SCAN:
  - pixel_valid=1. pixel_x/pixel_y must stay stable until valid&&ready.
  - On acceptance: x increments; when x=xmax, x wraps to xmin and y increments.
  - pixel_last=1 when x=xmax and y=ymax.
  - Acceptance of the last pixel -> CLR_START, with pixel_valid=0 the next cycle.
  - pixel_valid is never deasserted while a pixel is pending, except on abort.
- Abort: control_status_in[3]=1 sampled in SCAN -> pixel_valid drops next cycle -> CLR_START. A pixel accepted in the same cycle counts as delivered. ABORT=1 in other states is ignored until CLR_ABORT clears it.
- Degenerate triangles (collinear or all-equal vertices) still scan their bounding box; a single point emits one pixel with pixel_last=1.
- Throughput: one pixel per cycle with pixel_ready held high. Latency from START seen in IDLE to first pixel_valid is 5 cycles.
- Host software must not write the full CSR while BUSY=1.
- START is cleared 3 cycles before IDLE, so there is no retrigger.

Test Plan:
- Happy path: A=(2,3), B=(4,1), C=(3,5), START=1, ready=1 -> 15 pixels, (2,1),(3,1),(4,1),(2,2)...(4,5); pixel_last only on (4,5). CSR ends START=0, BUSY=0, DONE=1, with bit writes in the exact order listed above.
- Backpressure: same triangle, ready toggling 1,0,0,1 -> each pixel held stable while ready=0; still 15 pixels, no duplicates or skips.
- Clipping: A=(638,478), B=(700,479), C=(639,600) -> x 638..639, y 478..479, 4 pixels, last=(639,479). A=(700,10) for all vertices -> 0 pixels; CSR reaches DONE=1.
- Single point: A=B=C=(0,0) -> exactly one pixel (0,0) with pixel_last=1.
- Abort: 10x10 box, assert ABORT after 7 accepted pixels -> pixel_valid low next cycle; ABORT, START and BUSY cleared; DONE=1.
- Reset mid-SCAN: reset for 1 cycle -> next cycle state IDLE, pixel_valid=0, busy=0, csr_bit_load=0.
